// File: rtl/ov5640_cfg_sequencer.sv
// OV5640 power-up/config sequencer: camera reset, then walk a {addr,data} table issuing SCCB writes.
// Optional read-back verify of every write when CFG_VERIFY_EN is defined.
module ov5640_cfg_sequencer #(
    parameter int unsigned IDX_W         = 9,
    parameter int unsigned RST_HOLD      = 'h4FFFF,
    parameter int unsigned POST_RST_WAIT = 'h10000,
    parameter int unsigned DELAY_UNIT    = 25000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter int unsigned AUTO_START    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [23:0]      tbl_entry,
    output logic             sccb_req,
    output logic             sccb_rd,
    output logic [15:0]      sccb_addr,
    output logic [7:0]       sccb_wdata,
    input  logic             sccb_ack,
    input  logic             sccb_nack,
    input  logic [7:0]       sccb_rdata,
    output logic             cam_rstn,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx
);

    localparam int unsigned DLY_MAX  = 255 * DELAY_UNIT;
    localparam int unsigned CNT_MAX0 = (RST_HOLD > POST_RST_WAIT) ? RST_HOLD : POST_RST_WAIT;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > DLY_MAX) ? CNT_MAX0 : DLY_MAX;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [15:0] ADDR_END = 16'hFFFF;
    localparam logic [15:0] ADDR_DLY = 16'hFFFE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RST_WAIT,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_GAP,
        S_GAP_RD,
        S_READ,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic              req_q, req_d;
    logic              rd_q, rd_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cam_rstn_q, cam_rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              auto_q, auto_d;

    logic [15:0]       ent_addr_c;
    logic [7:0]        ent_data_c;
    logic              last_idx_c;
    logic              launch;
    logic              advance;
    logic              fail;

    assign ent_addr_c = tbl_entry[23:8];
    assign ent_data_c = tbl_entry[7:0];
    assign last_idx_c = (idx_q == {IDX_W{1'b1}});

`ifndef CFG_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^sccb_rdata;
`endif

    // Next-state logic; launch/advance/fail collect the shared transitions used by several states.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_idx_d  = err_idx_q;
        retry_d    = retry_q;
        req_d      = req_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cam_rstn_d = cam_rstn_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        auto_d     = auto_q;
        launch     = 1'b0;
        advance    = 1'b0;
        fail       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    launch = 1'b1;
                end
            end
            S_RST_HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cam_rstn_d = 1'b1;
                    cnt_d      = CNT_W'(POST_RST_WAIT);
                    state_d    = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ent_addr_c == ADDR_END) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (ent_addr_c == ADDR_DLY) begin
                    if (ent_data_c == 8'h00) begin
                        advance = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(ent_data_c) * CNT_W'(DELAY_UNIT);
                        state_d = S_DELAY;
                    end
                end else begin
                    addr_d  = ent_addr_c;
                    wdata_d = ent_data_c;
                    req_d   = 1'b1;
                    rd_d    = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_DELAY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (sccb_ack) begin
                    req_d = 1'b0;
                    if (sccb_nack) begin
                        fail = 1'b1;
                    end else begin
`ifdef CFG_VERIFY_EN
                        state_d = S_GAP_RD;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
            // One idle cycle with req low before a retried write.
            S_GAP: begin
                req_d   = 1'b1;
                rd_d    = 1'b0;
                state_d = S_WRITE;
            end
`ifdef CFG_VERIFY_EN
            S_GAP_RD: begin
                req_d   = 1'b1;
                rd_d    = 1'b1;
                state_d = S_READ;
            end
            S_READ: begin
                if (sccb_ack) begin
                    req_d = 1'b0;
                    rd_d  = 1'b0;
                    if (!sccb_nack && (sccb_rdata == wdata_q)) begin
                        advance = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entry finished: step to the next one, or stop after the last table slot.
        if (advance) begin
            retry_d = '0;
            if (last_idx_c) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_FETCH;
            end
        end

        if (fail) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = S_GAP;
            end else begin
                err_idx_d = idx_q;
                error_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_ERROR;
            end
        end

        if (launch) begin
            auto_d     = 1'b0;
            cam_rstn_d = 1'b0;
            cnt_d      = CNT_W'(RST_HOLD);
            idx_d      = '0;
            err_idx_d  = '0;
            retry_d    = '0;
            req_d      = 1'b0;
            rd_d       = 1'b0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
            state_d    = S_RST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            err_idx_q  <= '0;
            retry_q    <= '0;
            req_q      <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cam_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            auto_q     <= (AUTO_START != 0);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            err_idx_q  <= err_idx_d;
            retry_q    <= retry_d;
            req_q      <= req_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cam_rstn_q <= cam_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            auto_q     <= auto_d;
        end
    end

    assign tbl_idx    = idx_q;
    assign sccb_req   = req_q;
    assign sccb_rd    = rd_q;
    assign sccb_addr  = addr_q;
    assign sccb_wdata = wdata_q;
    assign cam_rstn   = cam_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Directed bench for ov5640_cfg_sequencer: table-driven scenarios plus hand-written reset/start/verify sequences.
module tb_ov5640_cfg_sequencer;

    localparam int unsigned IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W-1:0] tbl_idx;
    logic [23:0]      tbl_entry = 24'h0;
    logic             sccb_req;
    logic             sccb_rd;
    logic [15:0]      sccb_addr;
    logic [7:0]       sccb_wdata;
    logic             sccb_ack = 1'b0;
    logic             sccb_nack = 1'b0;
    logic [7:0]       sccb_rdata = 8'h00;
    logic             cam_rstn;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] err_idx;

    ov5640_cfg_sequencer #(
        .IDX_W(IDX_W), .RST_HOLD(16), .POST_RST_WAIT(8), .DELAY_UNIT(4), .MAX_RETRY(3), .AUTO_START(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
        .sccb_req(sccb_req), .sccb_rd(sccb_rd), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata),
        .sccb_ack(sccb_ack), .sccb_nack(sccb_nack), .sccb_rdata(sccb_rdata),
        .cam_rstn(cam_rstn), .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM.
    logic [23:0] rom [16];
    always @(posedge clk) tbl_entry <= rom[tbl_idx];

    // SCCB slave model: acks on the 5th cycle of a request; scripted NACKs and bad read-backs.
    logic [15:0] nack_addr = 16'h0;
    int          nack_cnt = 0;
    int          rd_bad_cnt = 0;
    int          nack_done = 0;
    int          rd_bad_done = 0;
    int          wait_cnt = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    logic [7:0]  last_wr = 8'h00;
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];

    always @(posedge clk) begin
        sccb_ack  <= 1'b0;
        sccb_nack <= 1'b0;
        if (rst) begin
            wait_cnt    <= 0;
            nack_done   <= 0;
            rd_bad_done <= 0;
            n_wr        <= 0;
            n_rd        <= 0;
            log_addr.delete();
            log_data.delete();
        end else if (sccb_req && !sccb_ack) begin
            if (wait_cnt == 4) begin
                wait_cnt <= 0;
                sccb_ack <= 1'b1;
                if (sccb_rd) begin
                    n_rd <= n_rd + 1;
                    if (rd_bad_done < rd_bad_cnt) begin
                        sccb_rdata  <= 8'h00;
                        rd_bad_done <= rd_bad_done + 1;
                    end else begin
                        sccb_rdata <= last_wr;
                    end
                end else begin
                    n_wr <= n_wr + 1;
                    log_addr.push_back(sccb_addr);
                    log_data.push_back(sccb_wdata);
                    if (sccb_addr == nack_addr && nack_done < nack_cnt) begin
                        sccb_nack <= 1'b1;
                        nack_done <= nack_done + 1;
                    end else begin
                        last_wr <= sccb_wdata;
                    end
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    typedef struct {
        logic [23:0] e0, e1, e2;
        bit          gen16;
        logic [15:0] nack_addr;
        int          nack_cnt;
        int          exp_lat;
        int          exp_nreq;
        logic [15:0] exp_a_first;
        logic [7:0]  exp_d_first;
        logic [15:0] exp_a_last;
        logic [7:0]  exp_d_last;
        bit          exp_done;
        bit          exp_err;
        int          exp_err_idx;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t cv;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns cycles from the start-sampling edge until cam_rstn is high.
    task automatic measure_hold(output int n);
        n = 0;
        while (!cam_rstn && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (!(done || error) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= budget) chk("end_timeout", 32'(n), 32'(budget - 1));
    endtask

    task automatic load_rom(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            if (v.gen16)       rom[i] = {16'(16'h4000 + i), 8'(8'hA0 + i)};
            else if (i == 0)   rom[i] = v.e0;
            else if (i == 1)   rom[i] = v.e1;
            else if (i == 2)   rom[i] = v.e2;
            else               rom[i] = 24'hFFFFFF;
        end
    endtask

    initial begin
        int n;
        int m;
        int n0;
        bit seen;

        vecs[0] = '{24'h300800, 24'h310311, 24'hFFFFFF, 1'b0, 16'h0000, 0, 10, 2,
                    16'h3008, 8'h00, 16'h3103, 8'h11, 1'b1, 1'b0, 0};
        vecs[1] = '{24'hFFFE03, 24'h300A56, 24'hFFFFFF, 1'b0, 16'h0000, 0, 24, 1,
                    16'h300A, 8'h56, 16'h300A, 8'h56, 1'b1, 1'b0, 0};
        vecs[2] = '{24'hFFFE00, 24'h300A56, 24'hFFFFFF, 1'b0, 16'h0000, 0, 12, 1,
                    16'h300A, 8'h56, 16'h300A, 8'h56, 1'b1, 1'b0, 0};
        vecs[3] = '{24'h300800, 24'h310311, 24'hFFFFFF, 1'b0, 16'h3103, 3, 10, 5,
                    16'h3008, 8'h00, 16'h3103, 8'h11, 1'b1, 1'b0, 0};
        vecs[4] = '{24'h300800, 24'h310311, 24'hFFFFFF, 1'b0, 16'h3103, 4, 10, 5,
                    16'h3008, 8'h00, 16'h3103, 8'h11, 1'b0, 1'b1, 1};
        vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 16'h0000, 0, 0, 0,
                    16'h0000, 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0, 0};
        vecs[6] = '{24'h0, 24'h0, 24'h0, 1'b1, 16'h0000, 0, 10, 16,
                    16'h4000, 8'hA0, 16'h400F, 8'hAF, 1'b1, 1'b0, 0};

        // Reset state, and start coincident with rst must lose.
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        apply_reset();
        chk("rst_cam_rstn", 32'(cam_rstn), 0);
        chk("rst_req", 32'(sccb_req), 0);
        chk("rst_rd", 32'(sccb_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_idx", 32'(err_idx), 0);
        chk("rst_tbl_idx", 32'(tbl_idx), 0);

        for (int i = 0; i < NV; i++) begin
            cv = vecs[i];
            load_rom(cv);
            nack_addr  = cv.nack_addr;
            nack_cnt   = cv.nack_cnt;
            rd_bad_cnt = 0;
            apply_reset();
            start_pulse();
            chk($sformatf("v%0d_busy_start", i), 32'(busy), 1);
            measure_hold(n);
            chk($sformatf("v%0d_rst_hold", i), 32'(n), 16);
            if (cv.exp_nreq > 0) begin
                m = 0;
                while (!sccb_req && m < 200) begin
                    @(posedge clk);
                    #1 m++;
                end
                chk($sformatf("v%0d_first_req_lat", i), 32'(m), 32'(cv.exp_lat));
            end
            wait_end(3000);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(cv.exp_done));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(cv.exp_err));
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
            chk($sformatf("v%0d_err_idx", i), 32'(err_idx), 32'(cv.exp_err_idx));
            chk($sformatf("v%0d_cam_rstn", i), 32'(cam_rstn), 1);
            if (cv.exp_err) begin
                repeat (20) @(posedge clk);
                #1;
                chk($sformatf("v%0d_req_after_err", i), 32'(sccb_req), 0);
            end
            chk($sformatf("v%0d_nreq", i), 32'(n_wr), 32'(cv.exp_nreq));
`ifndef CFG_VERIFY_EN
            chk($sformatf("v%0d_nread", i), 32'(n_rd), 0);
`endif
            if (log_addr.size() > 0) begin
                chk($sformatf("v%0d_addr_first", i), 32'(log_addr[0]), 32'(cv.exp_a_first));
                chk($sformatf("v%0d_data_first", i), 32'(log_data[0]), 32'(cv.exp_d_first));
                chk($sformatf("v%0d_addr_last", i), 32'(log_addr[log_addr.size()-1]), 32'(cv.exp_a_last));
                chk($sformatf("v%0d_data_last", i), 32'(log_data[log_data.size()-1]), 32'(cv.exp_d_last));
            end
        end

        // rst pulse while the second write is outstanding, then a full restart.
        load_rom(vecs[0]);
        nack_cnt = 0;
        apply_reset();
        start_pulse();
        seen = 1'b0;
        n = 0;
        while (!seen && n < 500) begin
            @(posedge clk);
            #1 n++;
            seen = sccb_req && !sccb_rd && (sccb_addr == 16'h3103);
        end
        chk("midrst_second_write_seen", 32'(seen), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_req", 32'(sccb_req), 0);
        chk("midrst_cam_rstn", 32'(cam_rstn), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tbl_idx", 32'(tbl_idx), 0);
        start_pulse();
        wait_end(3000);
        chk("midrst_restart_done", 32'(done), 1);
        chk("midrst_restart_nreq", 32'(n_wr), 2);

        // Start while busy is ignored; start after done re-runs including camera reset.
        load_rom(vecs[6]);
        apply_reset();
        start_pulse();
        n = 0;
        while (!sccb_req && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        start_pulse();
        chk("busy_start_cam_rstn", 32'(cam_rstn), 1);
        chk("busy_start_busy", 32'(busy), 1);
        wait_end(3000);
        chk("busy_start_nreq", 32'(n_wr), 16);
        chk("busy_start_done", 32'(done), 1);
        n0 = n_wr;
        start_pulse();
        chk("rerun_cam_rstn_low", 32'(cam_rstn), 0);
        chk("rerun_done_cleared", 32'(done), 0);
        measure_hold(n);
        chk("rerun_rst_hold", 32'(n), 16);
        wait_end(3000);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_nreq", 32'(n_wr - n0), 16);

`ifdef CFG_VERIFY_EN
        // One bad read-back costs one retry of the write.
        for (int i = 0; i < 16; i++) rom[i] = 24'hFFFFFF;
        rom[0] = 24'h123455;
        rd_bad_cnt = 1;
        apply_reset();
        start_pulse();
        wait_end(3000);
        chk("verify_done", 32'(done), 1);
        chk("verify_error", 32'(error), 0);
        chk("verify_nwrite", 32'(n_wr), 2);
        chk("verify_nread", 32'(n_rd), 2);
        chk("verify_last_data", 32'(last_wr), 32'h55);
        rd_bad_cnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
